lp805x_clksel_div: RTL and testbench

- Parametrised, single-clock successor to the two-input glitch-free clock switch.
- Generates a one-cycle clock-enable strobe from NSEL programmable divide ratios. The CPU/SFR side selects which ratio is active.
- Ratio changes take effect only at a period boundary, followed by a break-before-make gap, so downstream logic never sees a truncated or merged period.
- Feeds timer, UART and peripheral clock-enable inputs; no derived clocks are produced.

---
 rtl/lp805x_clksel_pkg.sv | 21 ++
 rtl/lp805x_clksel_cnt.sv | 34 +++
 rtl/lp805x_clksel_div.sv | 147 ++++++++++++++
 tb/tb_lp805x_clksel_div.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lp805x_clksel_pkg.sv
// Shared definitions for the lp805x clock-enable selector/divider:
// FSM state encoding, default parameter values and select validation.
package lp805x_clksel_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam int NSEL_DEF    = 4;
  localparam int SEL_W_DEF   = 2;
  localparam int CNT_W_DEF   = 8;
  localparam int GAP_CYC_DEF = 1;

  // A select index is usable only if it names an existing source.
  function automatic logic sel_valid(input int unsigned sel, input int unsigned nsel);
    return (sel < nsel);
  endfunction

endpackage

// File: rtl/lp805x_clksel_cnt.sv
// Divider counter for the active source. term flags the final cycle of a
// period (cnt >= D-1); a divide value of 0 parks the counter at 0.
module lp805x_clksel_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] d,
  input  logic             clear,
  input  logic             hold,
  output logic             term
);

  logic [CNT_W-1:0] cnt;

  // >= rather than == so a lowered divide value ends the period at once.
  assign term = (d != '0) && (cnt >= d - CNT_W'(1));

  // Period counter: clear on switch, freeze during the gap, wrap on terminal.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || d == '0) begin
      cnt <= '0;
    end else if (hold) begin
      cnt <= cnt;
    end else if (term) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/lp805x_clksel_div.sv
// Glitch-free selector over NSEL programmable clock-enable dividers.
// Source switches commit only at a period boundary of the old source and are
// followed by GAP_CYC dead cycles.
// Build option: define LP805X_CLKSEL_SYNC_EN to pass sel_i through a
// two-flop synchroniser (adds two cycles of request latency).
module lp805x_clksel_div
  import lp805x_clksel_pkg::*;
#(
  parameter int NSEL    = NSEL_DEF,
  parameter int SEL_W   = SEL_W_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int GAP_CYC = GAP_CYC_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SEL_W-1:0]      sel_i,
  input  logic [NSEL*CNT_W-1:0] div_i,
  output logic                  clk_en_o,
  output logic [SEL_W-1:0]      cur_sel_o,
  output logic                  busy_o,
  output logic                  sw_done_o
);

  logic [SEL_W-1:0] sel_s;

`ifdef LP805X_CLKSEL_SYNC_EN
  logic [SEL_W-1:0] sel_m1;
  logic [SEL_W-1:0] sel_m2;

  // Two-flop synchroniser for a select driven from another clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_m1 <= '0;
      sel_m2 <= '0;
    end else begin
      sel_m1 <= sel_i;
      sel_m2 <= sel_m1;
    end
  end

  assign sel_s = sel_m2;
`else
  assign sel_s = sel_i;
`endif

  state_t           state;
  logic [SEL_W-1:0] cur_sel;
  logic [SEL_W-1:0] pend_sel;
  logic [2:0]       gap_cnt;
  logic             clk_en;
  logic             busy;
  logic             sw_done;

  logic [CNT_W-1:0] d;
  logic             d_zero;
  logic             term;
  logic             req_vld;
  logic             new_req;
  logic             cancel;
  logic             commit;
  logic [SEL_W-1:0] target;

  assign d       = div_i[cur_sel*CNT_W +: CNT_W];
  assign d_zero  = (d == '0);
  assign req_vld = sel_valid(32'(sel_s), NSEL);
  assign new_req = req_vld && (sel_s != cur_sel);
  assign cancel  = (state == ST_PEND) && req_vld && (sel_s == cur_sel);
  assign commit  = (state == ST_PEND) && !cancel && (term || d_zero);
  // Last request wins, including one arriving on the commit edge itself.
  assign target  = new_req ? sel_s : pend_sel;

  lp805x_clksel_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (d),
    .clear (commit),
    .hold  (state == ST_GAP),
    .term  (term)
  );

  // Switch FSM: RUN -> PEND (wait for old period end) -> GAP -> RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      cur_sel  <= '0;
      pend_sel <= '0;
      gap_cnt  <= '0;
      clk_en   <= 1'b0;
      busy     <= 1'b0;
      sw_done  <= 1'b0;
    end else begin
      sw_done <= 1'b0;
      case (state)
        ST_RUN: begin
          clk_en <= term;
          if (new_req) begin
            pend_sel <= sel_s;
            state    <= ST_PEND;
            busy     <= 1'b1;
          end
        end
        ST_PEND: begin
          // term is already 0 for D=0, so the final strobe is suppressed there.
          clk_en <= term;
          if (cancel) begin
            state <= ST_RUN;
            busy  <= 1'b0;
          end else if (commit) begin
            cur_sel <= target;
            sw_done <= 1'b1;
            if (GAP_CYC > 0) begin
              state   <= ST_GAP;
              gap_cnt <= '0;
            end else begin
              state <= ST_RUN;
              busy  <= 1'b0;
            end
          end else if (req_vld) begin
            pend_sel <= sel_s;
          end
        end
        ST_GAP: begin
          clk_en <= 1'b0;
          if (gap_cnt == 3'(GAP_CYC - 1)) begin
            state <= ST_RUN;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 3'd1;
          end
        end
        default: begin
          state  <= ST_RUN;
          clk_en <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

  assign clk_en_o  = clk_en;
  assign cur_sel_o = cur_sel;
  assign busy_o    = busy;
  assign sw_done_o = sw_done;

endmodule

// File: tb/tb_lp805x_clksel_div.sv
// Self-checking bench for lp805x_clksel_div (default parameters).
module tb_lp805x_clksel_div;

  localparam int NSEL = 4;
  localparam int GAP  = 1;

  logic        clk;
  logic        rst_n;
  logic [1:0]  sel;
  logic [31:0] div;
  logic        clk_en;
  logic [1:0]  cur_sel;
  logic        busy;
  logic        sw_done;

  int n_checks = 0;
  int n_fail   = 0;

  lp805x_clksel_div dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sel_i     (sel),
    .div_i     (div),
    .clk_en_o  (clk_en),
    .cur_sel_o (cur_sel),
    .busy_o    (busy),
    .sw_done_o (sw_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: position within the current period, the selected and
  // pending sources, and the number of dead cycles still to run.
  int m_pos, m_cur, m_pend, m_gap, m_s1, m_s2;
  bit m_pending, m_busy, m_en, m_done;

  int d_v, eff, n_pos, n_cur, n_pend, n_gap;
  bit last, n_pending, n_busy, n_en, n_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pos <= 0; m_cur <= 0; m_pend <= 0; m_gap <= 0; m_s1 <= 0; m_s2 <= 0;
      m_pending <= 0; m_busy <= 0; m_en <= 0; m_done <= 0;
    end else begin
`ifdef LP805X_CLKSEL_SYNC_EN
      eff = m_s2;
      m_s2 <= m_s1;
      m_s1 <= int'(sel);
`else
      eff = int'(sel);
`endif
      n_pos = m_pos; n_cur = m_cur; n_pend = m_pend; n_gap = m_gap;
      n_pending = m_pending; n_busy = m_busy; n_en = 0; n_done = 0;
      d_v = int'(div[m_cur*8 +: 8]);
      if (m_gap > 0) begin
        n_gap = m_gap - 1;
        if (n_gap == 0) n_busy = 0;
      end else begin
        last  = (d_v != 0) && (m_pos + 1 >= d_v);
        n_pos = (d_v == 0 || last) ? 0 : m_pos + 1;
        n_en  = last;
        if (!m_pending) begin
          if (eff < NSEL && eff != m_cur) begin
            n_pending = 1; n_pend = eff; n_busy = 1;
          end
        end else if (eff == m_cur) begin
          n_pending = 0; n_busy = 0;
        end else begin
          if (eff < NSEL) n_pend = eff;
          if (last || d_v == 0) begin
            n_cur = n_pend; n_pos = 0; n_done = 1; n_pending = 0;
            if (GAP > 0) n_gap = GAP;
            else n_busy = 0;
          end
        end
      end
      m_pos <= n_pos; m_cur <= n_cur; m_pend <= n_pend; m_gap <= n_gap;
      m_pending <= n_pending; m_busy <= n_busy; m_en <= n_en; m_done <= n_done;
    end
  end

  logic [4:0] obs, exp_v;
  assign obs   = {clk_en, busy, sw_done, cur_sel};
  assign exp_v = {m_en, m_busy, m_done, 2'(m_cur)};

  task automatic do_reset(input logic [31:0] dv, input logic [1:0] s);
    @(negedge clk);
    rst_n = 1'b0;
    div   = dv;
    sel   = s;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sel   = 2'd0;
    div   = 32'h0308_0204;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (obs !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_state: got %b required 00000", obs);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int strobes[$];
    do_reset(32'h0308_0204, 2'd0);
    for (int i = 1; i <= 13; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL basic edge %0d: got %b required %b", i, obs, exp_v);
      end
      if (clk_en) strobes.push_back(i);
    end
    n_checks++;
    if (strobes.size() != 3 || strobes[0] != 4 || strobes[1] != 8 || strobes[2] != 12) begin
      n_fail++;
      $display("FAIL basic_strobe_edges: got %p required '{4,8,12}", strobes);
    end
  endtask

  task automatic test_switch();
    int done_edge = 0;
    int next_edge = 0;
    bit en_at_done = 0;
    do_reset(32'h0308_0208, 2'd0);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL switch edge %0d: got %b required %b", i, obs, exp_v);
      end
      if (sw_done) begin done_edge = i; en_at_done = clk_en; end
      else if (clk_en && done_edge > 0 && next_edge == 0) next_edge = i;
      if (i == 2) sel = 2'd2;
    end
    n_checks++;
    if (done_edge != 8 || !en_at_done) begin
      n_fail++;
      $display("FAIL switch_commit: got edge %0d strobe %0d required edge 8 strobe 1", done_edge, en_at_done);
    end
    n_checks++;
    if (next_edge != 17 || cur_sel !== 2'd2) begin
      n_fail++;
      $display("FAIL switch_new_period: got edge %0d sel %0d required edge 17 sel 2", next_edge, cur_sel);
    end
  endtask

  task automatic test_cancel();
    int dones = 0;
    int strobes = 0;
    do_reset(32'h0308_0208, 2'd0);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL cancel edge %0d: got %b required %b", i, obs, exp_v);
      end
      if (sw_done) dones++;
      if (clk_en) strobes++;
      if (i == 1) sel = 2'd1;
      if (i == 2) sel = 2'd3;
      if (i == 4) sel = 2'd0;
    end
    n_checks++;
    if (dones != 0 || strobes != 2 || busy !== 1'b0 || cur_sel !== 2'd0) begin
      n_fail++;
      $display("FAIL cancel_result: got done %0d strobes %0d busy %b required 0 2 0", dones, strobes, busy);
    end
  endtask

  task automatic test_d_zero();
    int strobes = 0;
    do_reset(32'h0308_0200, 2'd1);
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL d_zero edge %0d: got %b required %b", i, obs, exp_v);
      end
      if (clk_en) strobes++;
    end
    n_checks++;
    if (strobes < 3 || cur_sel !== 2'd1) begin
      n_fail++;
      $display("FAIL d_zero_result: got strobes %0d sel %0d required >=3 sel 1", strobes, cur_sel);
    end
  endtask

  task automatic test_d_one();
    int ones = 0;
    do_reset(32'h0308_0104, 2'd1);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL d_one edge %0d: got %b required %b", i, obs, exp_v);
      end
      if (i >= 6 && clk_en) ones++;
    end
    n_checks++;
    if (ones != 11) begin
      n_fail++;
      $display("FAIL d_one_continuous: got %0d strobes required 11", ones);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(32'h0308_0208, 2'd0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL reset_mid edge %0d: got %b required %b", i, obs, exp_v);
      end
      if (i == 1) sel = 2'd1;
    end
`ifndef LP805X_CLKSEL_SYNC_EN
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_pend: got busy %b required 1", busy);
    end
`endif
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_in_pend: got %b required 00000", obs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL reset_mid2 edge %0d: got %b required %b", i, obs, exp_v);
      end
    end
    n_checks++;
    if (sw_done !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_gap_entry: got sw_done %b required 1", sw_done);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_in_gap: got %b required 00000", obs);
    end
    test_basic();
  endtask

  task automatic test_random();
    logic [31:0] dv;
    dv = 32'h0;
    for (int k = 0; k < 4; k++) dv[k*8 +: 8] = 8'($urandom_range(0, 6));
    do_reset(dv, 2'd0);
    for (int i = 1; i <= 800; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL random cycle %0d: got %b required %b", i, obs, exp_v);
      end
      if ($urandom_range(0, 7) == 0) sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 31) == 0) begin
        dv = div;
        dv[$urandom_range(0, 3)*8 +: 8] = 8'($urandom_range(0, 6));
        div = dv;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    sel   = 2'd0;
    div   = 32'h0;
    test_reset();
    test_basic();
    test_switch();
    test_cancel();
    test_d_zero();
    test_d_one();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
